// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: owns the shared 7800 system bus between the 6502 and MARIA DMA.
// Sequences the CPU halt handshake, inserts a turnaround cycle before and after
// each DMA burst, enforces a minimum CPU window between bursts and forcibly
// returns the bus if a burst overruns the watchdog limit.
module sys_bus_arbiter #(
  parameter int             MAX_DMA = 512,
  parameter int             MIN_CPU = 2,
  parameter int             WR_WAIT = 3,
  parameter int             CSW     = 4,
  parameter logic [CSW-1:0] CS_NONE = {CSW{1'b0}}
) (
  input  logic           memclk,
  input  logic           reset,
  input  logic           dma_req,
  input  logic           dma_done,
  input  logic [15:0]    cpu_ab,
  input  logic           cpu_rw,
  input  logic [15:0]    maria_ab,
  input  logic [CSW-1:0] cs_in,
  output logic           halt_b,
  output logic           dma_grant,
  output logic           dma_ack,
  output logic [15:0]    ab_out,
  output logic           rw_out,
  output logic [CSW-1:0] cs_buf,
  output logic           timeout_err,
  output logic [2:0]     state_o
);

  localparam int DCW  = $clog2(MAX_DMA) + 1;
  localparam int WINW = (MIN_CPU > 0) ? $clog2(MIN_CPU + 1) : 1;
  localparam int WRW  = (WR_WAIT > 0) ? $clog2(WR_WAIT + 1) : 1;

  localparam logic [DCW-1:0]  DMA_LAST = DCW'(MAX_DMA - 1);
  localparam logic [DCW-1:0]  DMA_ONE  = DCW'(1);
  localparam logic [WINW-1:0] WIN_MIN  = WINW'(MIN_CPU);
  localparam logic [WINW-1:0] WIN_ONE  = WINW'(1);
  localparam logic [WRW-1:0]  WR_LAST  = WRW'(WR_WAIT - 1);
  localparam logic [WRW-1:0]  WR_MAX   = WRW'(WR_WAIT);
  localparam logic [WRW-1:0]  WR_ONE   = WRW'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_HANDOVER  = 3'd2,
    ST_GRANT     = 3'd3,
    ST_RELEASE   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [DCW-1:0]  dma_cnt_r;
  logic [WINW-1:0] win_cnt_r;
  logic [WRW-1:0]  wr_cnt_r;
  logic            wd_expire_s;
  logic            wr_expire_s;
  logic            halt_b_s;
  logic            grant_s;
  logic            ack_s;
  logic            timeout_s;
  logic            halt_b_r;
  logic            grant_r;
  logic            ack_r;
  logic            timeout_r;
  logic [CSW-1:0]  cs_buf_r;

  // State register; reset hands the bus straight back to the CPU.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, including detection of the two timeout exits.
  always_comb begin
    next_state_s = ST_IDLE;
    wd_expire_s  = 1'b0;
    wr_expire_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dma_req && (win_cnt_r >= WIN_MIN)) begin
          next_state_s = ST_HALT_WAIT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HALT_WAIT: begin
        if (!dma_req) begin
          next_state_s = ST_IDLE;
        end else if (cpu_rw) begin
          next_state_s = ST_HANDOVER;
        end else if (wr_cnt_r >= WR_LAST) begin
          // This sampled write is the WR_WAIT-th in a row: give up waiting.
          next_state_s = ST_HANDOVER;
          wr_expire_s  = 1'b1;
        end else begin
          next_state_s = ST_HALT_WAIT;
        end
      end
      ST_HANDOVER: begin
        next_state_s = ST_GRANT;
      end
      ST_GRANT: begin
        // A normal end takes priority over a coincident watchdog expiry.
        if (dma_done || !dma_req) begin
          next_state_s = ST_RELEASE;
        end else if (dma_cnt_r >= DMA_LAST) begin
          next_state_s = ST_RELEASE;
          wd_expire_s  = 1'b1;
        end else begin
          next_state_s = ST_GRANT;
        end
      end
      ST_RELEASE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with state_o.
  always_comb begin
    halt_b_s  = (next_state_s == ST_IDLE);
    grant_s   = (next_state_s == ST_GRANT);
    ack_s     = (next_state_s == ST_GRANT) && (state_r != ST_GRANT);
    timeout_s = timeout_r | wd_expire_s | wr_expire_s;
  end

  // Registered control outputs; timeout flag is sticky until reset.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      halt_b_r  <= 1'b1;
      grant_r   <= 1'b0;
      ack_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      halt_b_r  <= halt_b_s;
      grant_r   <= grant_s;
      ack_r     <= ack_s;
      timeout_r <= timeout_s;
    end
  end

  // CPU window counter: cleared as the bus comes back, saturates at MIN_CPU.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      win_cnt_r <= {WINW{1'b0}};
    end else if (state_r == ST_RELEASE) begin
      win_cnt_r <= {WINW{1'b0}};
    end else if ((state_r == ST_IDLE) && (win_cnt_r < WIN_MIN)) begin
      win_cnt_r <= win_cnt_r + WIN_ONE;
    end else begin
      win_cnt_r <= win_cnt_r;
    end
  end

  // Consecutive CPU write counter, live only while waiting for the halt.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      wr_cnt_r <= {WRW{1'b0}};
    end else if (state_r != ST_HALT_WAIT) begin
      wr_cnt_r <= {WRW{1'b0}};
    end else if (!cpu_rw && (wr_cnt_r < WR_MAX)) begin
      wr_cnt_r <= wr_cnt_r + WR_ONE;
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

  // DMA burst length counter for the watchdog, live only while granted.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      dma_cnt_r <= {DCW{1'b0}};
    end else if (state_r != ST_GRANT) begin
      dma_cnt_r <= {DCW{1'b0}};
    end else if (dma_cnt_r < DMA_LAST) begin
      dma_cnt_r <= dma_cnt_r + DMA_ONE;
    end else begin
      dma_cnt_r <= dma_cnt_r;
    end
  end

  // Chip-select pipeline register feeding the read-data mux.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      cs_buf_r <= CS_NONE;
    end else begin
      cs_buf_r <= cs_in;
    end
  end

  assign halt_b      = halt_b_r;
  assign dma_grant   = grant_r;
  assign dma_ack     = ack_r;
  assign timeout_err = timeout_r;
  assign cs_buf      = cs_buf_r;
  assign state_o     = state_r;
  assign ab_out      = grant_r ? maria_ab : cpu_ab;
  assign rw_out      = grant_r ? 1'b1 : cpu_rw;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed-vector bench with a scoreboard queue. The
// stimulus pushes the hand-derived expected bus state for each cycle; an
// independent monitor pops and compares on the falling clock edge.
module tb_sys_bus_arbiter;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] H = 3'd1;
  localparam logic [2:0] O = 3'd2;
  localparam logic [2:0] G = 3'd3;
  localparam logic [2:0] R = 3'd4;

  logic        memclk   = 1'b0;
  logic        reset    = 1'b1;
  logic        dma_req  = 1'b0;
  logic        dma_done = 1'b0;
  logic [15:0] cpu_ab   = 16'h0000;
  logic        cpu_rw   = 1'b1;
  logic [15:0] maria_ab = 16'h0000;
  logic [3:0]  cs_in    = 4'h0;
  logic        halt_b;
  logic        dma_grant;
  logic        dma_ack;
  logic [15:0] ab_out;
  logic        rw_out;
  logic [3:0]  cs_buf;
  logic        timeout_err;
  logic [2:0]  state_o;

  sys_bus_arbiter #(
    .MAX_DMA(8),
    .MIN_CPU(2),
    .WR_WAIT(3),
    .CSW(4),
    .CS_NONE(4'd0)
  ) dut (
    .memclk(memclk),
    .reset(reset),
    .dma_req(dma_req),
    .dma_done(dma_done),
    .cpu_ab(cpu_ab),
    .cpu_rw(cpu_rw),
    .maria_ab(maria_ab),
    .cs_in(cs_in),
    .halt_b(halt_b),
    .dma_grant(dma_grant),
    .dma_ack(dma_ack),
    .ab_out(ab_out),
    .rw_out(rw_out),
    .cs_buf(cs_buf),
    .timeout_err(timeout_err),
    .state_o(state_o)
  );

  always #5 memclk = ~memclk;

  typedef struct {
    logic        halt_b;
    logic        grant;
    logic        ack;
    logic        tmo;
    logic [2:0]  st;
    logic [15:0] ab;
    logic        rw;
    logic [3:0]  cs;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc_num  = 0;
  logic [2:0] prev_st  = 3'd0;
  logic [3:0] prev_cs  = 4'd0;

  // One clock cycle: drive inputs just after the edge and queue the expected
  // outputs for this cycle (st/tmo are the hand-derived state after the edge).
  task automatic cyc(input logic rst_v, input logic req, input logic done,
                     input logic rw, input logic [2:0] st, input logic tmo);
    exp_t        e;
    logic        rst_edge;
    logic [15:0] cval;
    @(posedge memclk);
    rst_edge = reset;
    #1;
    cyc_num  = cyc_num + 1;
    cval     = 16'(cyc_num);
    reset    = rst_v;
    dma_req  = req;
    dma_done = done;
    cpu_rw   = rw;
    cpu_ab   = 16'h1234 ^ cval;
    maria_ab = 16'hA000 + cval;
    cs_in    = cval[3:0] ^ 4'h5;
    e.halt_b = (st == I);
    e.grant  = (st == G);
    e.ack    = (st == G) && (prev_st != G);
    e.tmo    = tmo;
    e.st     = st;
    e.ab     = e.grant ? maria_ab : cpu_ab;
    e.rw     = e.grant ? 1'b1 : rw;
    e.cs     = (rst_edge || rst_v) ? 4'd0 : prev_cs;
    e.cyc    = cyc_num;
    sb_q.push_back(e);
    prev_st  = st;
    prev_cs  = cs_in;
  endtask

  task automatic chk(input string nm, input int cy, input logic [15:0] act,
                     input logic [15:0] expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_errors = n_errors + 1;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cy, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge memclk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("halt_b",      mon_e.cyc, {15'd0, halt_b},      {15'd0, mon_e.halt_b});
      chk("dma_grant",   mon_e.cyc, {15'd0, dma_grant},   {15'd0, mon_e.grant});
      chk("dma_ack",     mon_e.cyc, {15'd0, dma_ack},     {15'd0, mon_e.ack});
      chk("timeout_err", mon_e.cyc, {15'd0, timeout_err}, {15'd0, mon_e.tmo});
      chk("state_o",     mon_e.cyc, {13'd0, state_o},     {13'd0, mon_e.st});
      chk("ab_out",      mon_e.cyc, ab_out,               mon_e.ab);
      chk("rw_out",      mon_e.cyc, {15'd0, rw_out},      {15'd0, mon_e.rw});
      chk("cs_buf",      mon_e.cyc, {12'd0, cs_buf},      {12'd0, mon_e.cs});
    end
  end

  // Hard time limit in case the run stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit reached");
  end

  // Directed stimulus; arguments are (reset, dma_req, dma_done, cpu_rw, state, timeout_err).
  initial begin
    int guard;
    // Reset held, then 20 idle cycles with no request.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, I, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, I, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b1, I, 1'b0);

    // Normal burst; dma_done lands on the 8th grant cycle together with the watchdog.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, I, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, O, 1'b0);
    repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b1, G, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, G, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, R, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, I, 1'b0);

    // Two CPU writes during the halt wait delay the grant by two cycles, no error.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, I, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, O, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, G, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, R, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, I, 1'b0);

    // Watchdog: no dma_done, grant lasts exactly 8 cycles and sets timeout_err.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, I, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, O, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b1, G, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, R, 1'b1);
    // Request still held: the CPU keeps the bus through the window before the next halt.
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, I, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, H, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, O, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, G, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, G, 1'b1);
    // Reset asserted between edges mid-grant: bus returns at once, flag cleared.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, I, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, I, 1'b0);

    // Three consecutive writes during the halt wait: timeout_err set, grant proceeds.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, I, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, I, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, H, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, O, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, G, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, R, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, I, 1'b1);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while ((sb_q.size() > 0) && (guard < 10)) begin
      @(negedge memclk);
      guard = guard + 1;
    end
    @(posedge memclk);
    if (sb_q.size() > 0) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
Owns the shared 7800 system bus (AB, RW, registered chip-select) between the 6502 and MARIA DMA. It sequences the CPU halt handshake so that DMA only takes the bus on a safe CPU cycle. It inserts turnaround cycles and enforces a minimum CPU window between DMA bursts. A watchdog forcibly returns the bus if a DMA burst overruns. It sits between cpu_inst/maria_inst and the address/CS decode feeding RAM0/RAM1/BIOS/cart/TIA/RIOT.

Parameters:
MAX_DMA, 512, maximum memclk cycles in GRANT before forced release (watchdog).
MIN_CPU, 2, minimum memclk cycles in IDLE after a release before a new halt may start.
WR_WAIT, 3, maximum consecutive CPU write cycles tolerated in HALT_WAIT before timeout_err is set.
CSW, 4, width of the chip-select code.
CS_NONE, 0, chip-select code meaning no device selected.

Ports:
memclk  in  1  bus clock.
reset  in  1  async, active-high.
dma_req  in  1  MARIA requests the bus; level, held until dma_done.
dma_done  in  1  one-cycle pulse from MARIA: last DMA access complete.
cpu_ab  in  16  CPU address.
cpu_rw  in  1  CPU read(1)/write(0).
maria_ab  in  16  MARIA DMA address.
cs_in  in  CSW  decoded chip-select for the current ab_out.
halt_b  out  1  active-low halt to CPU.
dma_grant  out  1  MARIA drives AB (maria_drive_AB).
dma_ack  out  1  one-cycle pulse on the first GRANT cycle.
ab_out  out  16  muxed system address.
rw_out  out  1  system RW.
cs_buf  out  CSW  registered chip-select for the read-data mux.
timeout_err  out  1  sticky error flag; a sticky flag cannot be cleared by the bus it is protecting, so it clears only on reset.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, halt_b = 1, dma_grant = 0, dma_ack = 0.
  - cs_buf = CS_NONE, timeout_err = 0, all counters = 0.
- Datapath:
  - ab_out = dma_grant ? maria_ab : cpu_ab (combinational).
  - rw_out = dma_grant ? 1 : cpu_rw. MARIA never writes.
  - cs_buf <= cs_in on every memclk edge. This gives 1-cycle read-select latency.
- States:
  - IDLE (0): CPU owns the bus, halt_b = 1.
    - The window counter increments up to MIN_CPU.
    - If dma_req = 1 and window >= MIN_CPU, go to HALT_WAIT.
  - HALT_WAIT (1): halt_b = 0.
    - The 6502 cannot stop on a write, so the block waits for cpu_rw = 1.
    - When cpu_rw = 1 is sampled, go to HANDOVER.
    - Each sampled cpu_rw = 0 increments wr_cnt. If wr_cnt reaches WR_WAIT, set timeout_err and go to HANDOVER anyway.
    - If dma_req drops, return to IDLE with halt_b = 1 next cycle.
  - HANDOVER (2): one turnaround cycle. halt_b = 0, dma_grant = 0. Then go to GRANT.
  - GRANT (3): halt_b = 0, dma_grant = 1. dma_ack is high on the first GRANT cycle only.
    - dma_cnt increments each cycle.
    - Exit to RELEASE on dma_done, on dma_req = 0, or when dma_cnt = MAX_DMA-1. The watchdog exit also sets timeout_err.
  - RELEASE (4): dma_grant = 0, halt_b = 0 for one cycle. Then go to IDLE, where halt_b = 1 and the window counter clears to 0.
- Counters:
  - dma_cnt clears on entry to GRANT. Its width is clog2(MAX_DMA)+1.
  - wr_cnt clears on entry to HALT_WAIT.
  - Counters saturate, never wrap.
- Simultaneous events:
  - dma_done and watchdog expiry in the same cycle: normal release, timeout_err not set.
  - A dma_req still high after RELEASE waits the MIN_CPU window.
- Reset mid-GRANT: bus returns to the CPU immediately (async). dma_grant = 0 and halt_b = 1 in the same instant.
- Unused state encodings (5-7) return to IDLE on the next edge.

Test Plan:
- Reset, dma_req = 0: halt_b = 1, dma_grant = 0, ab_out = cpu_ab, cs_buf = CS_NONE across 20 cycles.
- cpu_rw = 1, dma_req rises at cycle N:
  - halt_b = 0 at N+1, HANDOVER at N+2, dma_grant = 1 and dma_ack = 1 at N+3.
  - ab_out = maria_ab and rw_out = 1 while granted.
  - dma_done at N+10: dma_grant = 0 at N+11, halt_b = 1 at N+12.
- cpu_rw = 0 for 2 cycles then 1 during HALT_WAIT: grant is delayed by exactly 2 cycles and timeout_err stays 0. Holding cpu_rw = 0 for 3 cycles sets timeout_err = 1 and the grant proceeds.
- MAX_DMA = 8, no dma_done: dma_grant is high exactly 8 cycles, then RELEASE and timeout_err = 1. dma_done coincident with cycle 8 leaves timeout_err = 0.
- Back-to-back requests (dma_req held high): the next halt_b fall happens no earlier than MIN_CPU = 2 cycles after halt_b returns to 1.
- Assert reset during GRANT: dma_grant = 0 and halt_b = 1 immediately, timeout_err = 0, state_o = 0.
